// File: rtl/flpdiv_seq.sv
// Sequential binary32 divider: radix-2 restoring mantissa division, one quotient
// bit per cycle, round-to-nearest-even, valid/ready handshake on both sides.
module flpdiv_seq #(
    parameter int unsigned Bits   = 32,
    parameter int unsigned Q_BITS = 26
) (
    input  logic            iClk,
    input  logic            iRst_n,
    input  logic            iValid,
    output logic            oReady,
    input  logic [Bits-1:0] iA,
    input  logic [Bits-1:0] iB,
    output logic            oValid,
    input  logic            iReady,
    output logic [Bits-1:0] oZ
);
    localparam int unsigned E_BITS   = 8;
    localparam int unsigned M_BITS   = 24;
    localparam int unsigned F_BITS   = M_BITS - 1;
    localparam int unsigned R_BITS   = M_BITS + 1;
    localparam int unsigned X_BITS   = 10;
    localparam int unsigned LZ_W     = 5;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned SH_MAX   = Q_BITS + 1;
    localparam int unsigned SH_W     = 5;
    localparam int unsigned MAG_W    = Bits - 1;
    localparam int unsigned EXT_W    = Q_BITS + SH_MAX;
    localparam int unsigned EXP_BIAS = 127;

    localparam logic signed [X_BITS-1:0] EXP_OVF  = 10'sd255;
    localparam logic signed [X_BITS-1:0] EXP_ZERO = 10'sd0;
    localparam logic [Bits-1:0]          QNAN     = 32'hFFC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_ROUND,
        S_DONE
    } state_e;

    state_e                    state_q;
    logic [Bits-1:0]           a_q, b_q;
    logic [M_BITS-1:0]         mb_q;
    logic [R_BITS-1:0]         rem_q;
    logic [Q_BITS-1:0]         q_q;
    logic signed [X_BITS-1:0]  eq_q;
    logic                      sign_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [Bits-1:0]           z_q;
    logic                      valid_q;
    logic                      ready_q;

    assign oReady = ready_q;
    assign oValid = valid_q;
    assign oZ     = z_q;

    // Leading-zero count of a 24-bit significand (24 when all zero).
    function automatic logic [LZ_W-1:0] lzc(input logic [M_BITS-1:0] m);
        logic [LZ_W-1:0] n;
        n = LZ_W'(M_BITS);
        for (int i = 0; i < int'(M_BITS); i++) begin
            if (m[i]) n = LZ_W'(int'(M_BITS) - 1 - i);
        end
        return n;
    endfunction

    // Operand classification, subnormal normalisation and quotient exponent.
    logic [E_BITS-1:0]        fa, fb;
    logic [F_BITS-1:0]        xa, xb;
    logic                     nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic                     sign_d, special_d;
    logic [M_BITS-1:0]        ma_raw, mb_raw, ma_n, mb_d;
    logic [LZ_W-1:0]          lz_a, lz_b;
    logic signed [X_BITS-1:0] ea, eb, eq_d;
    logic                     a_lt_b;
    logic [R_BITS-1:0]        rem_d;
    logic [Bits-1:0]          spec_z_d;

    always_comb begin
        fa       = a_q[Bits-2 -: E_BITS];
        fb       = b_q[Bits-2 -: E_BITS];
        xa       = a_q[F_BITS-1:0];
        xb       = b_q[F_BITS-1:0];
        nan_a    = (&fa) && (|xa);
        nan_b    = (&fb) && (|xb);
        inf_a    = (&fa) && !(|xa);
        inf_b    = (&fb) && !(|xb);
        zero_a   = !(|fa) && !(|xa);
        zero_b   = !(|fb) && !(|xb);
        sign_d   = a_q[Bits-1] ^ b_q[Bits-1];

        ma_raw   = {|fa, xa};
        mb_raw   = {|fb, xb};
        lz_a     = lzc(ma_raw);
        lz_b     = lzc(mb_raw);
        ma_n     = ma_raw << lz_a;
        mb_d     = mb_raw << lz_b;
        ea       = (|fa) ? X_BITS'(fa) : X_BITS'(1) - X_BITS'(lz_a);
        eb       = (|fb) ? X_BITS'(fb) : X_BITS'(1) - X_BITS'(lz_b);
        a_lt_b   = ma_n < mb_d;
        eq_d     = ea - eb + X_BITS'(EXP_BIAS) - X_BITS'(a_lt_b);
        rem_d    = a_lt_b ? {ma_n, 1'b0} : {1'b0, ma_n};

        special_d = nan_a || nan_b || inf_a || inf_b || zero_a || zero_b;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            spec_z_d = QNAN;
        end else if (inf_a || zero_b) begin
            spec_z_d = {sign_d, {E_BITS{1'b1}}, F_BITS'(0)};
        end else begin
            spec_z_d = {sign_d, MAG_W'(0)};
        end
    end

    // One restoring step: subtract when the divisor fits, then shift.
    logic              ge;
    logic [R_BITS-1:0] diff, rem_step;
    logic [Q_BITS-1:0] q_step;

    always_comb begin
        ge       = rem_q >= {1'b0, mb_q};
        diff     = ge ? rem_q - {1'b0, mb_q} : rem_q;
        rem_step = diff << 1;
        q_step   = {q_q[Q_BITS-2:0], ge};
    end

    // Denormalise on underflow, then RNE; the hidden bit folds into the exponent sum.
    logic              ovf, unf, lost, sticky, rnd;
    logic [X_BITS-1:0] sh_full;
    logic [SH_W-1:0]   shamt;
    logic [EXT_W-1:0]  q_ext;
    logic [Q_BITS-1:0] q_s;
    logic [E_BITS-1:0] base;
    logic [MAG_W-1:0]  mag;
    logic [Bits-1:0]   round_z;

    always_comb begin
        ovf     = eq_q >= EXP_OVF;
        unf     = eq_q <= EXP_ZERO;
        sh_full = X_BITS'(1) - eq_q;
        if (!unf) begin
            shamt = '0;
        end else if (sh_full > X_BITS'(SH_MAX)) begin
            shamt = SH_W'(SH_MAX);
        end else begin
            shamt = sh_full[SH_W-1:0];
        end
        q_ext   = {q_q, SH_MAX'(0)} >> shamt;
        q_s     = q_ext[EXT_W-1 -: Q_BITS];
        lost    = |q_ext[SH_MAX-1:0];
        sticky  = q_s[0] | lost | (|rem_q);
        rnd     = q_s[1] & (sticky | q_s[2]);
        base    = unf ? '0 : eq_q[E_BITS-1:0] - E_BITS'(1);
        mag     = {base, F_BITS'(0)} + MAG_W'(q_s[Q_BITS-1:2]) + MAG_W'(rnd);
        round_z = ovf ? {sign_q, {E_BITS{1'b1}}, F_BITS'(0)} : {sign_q, mag};
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mb_q    <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            eq_q    <= '0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
            z_q     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iValid) begin
                        a_q     <= iA;
                        b_q     <= iB;
                        ready_q <= 1'b0;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    sign_q <= sign_d;
                    if (special_d) begin
                        z_q     <= spec_z_d;
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        eq_q    <= eq_d;
                        rem_q   <= rem_d;
                        mb_q    <= mb_d;
                        q_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_step;
                    q_q   <= q_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(Q_BITS - 1)) state_q <= S_ROUND;
                end
                S_ROUND: begin
                    z_q     <= round_z;
                    valid_q <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (iReady) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
